// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the mux scan sequencer: FSM state encoding,
// channel count and frame type.
package mux_scan_sequencer_pkg;

   localparam int unsigned N_CH = 4;
   localparam logic [1:0]  LAST_CH = 2'(N_CH - 1);

   typedef logic [N_CH-1:0] frame_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_SAMPLE  = 2'd2,
      ST_DELIVER = 2'd3
   } scan_state_e;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Frame delivery port: a 4-bit frame with valid/ready handshake.
// The sequencer is the master; the consumer is the slave.
interface mux_scan_sequencer_if;
   import mux_scan_sequencer_pkg::*;

   frame_t frame;
   logic   frame_valid;
   logic   frame_ready;

   modport master (output frame, output frame_valid, input frame_ready);
   modport slave  (input frame, input frame_valid, output frame_ready);

endinterface

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// Dwell down-counter: loads a fixed reload value, decrements on request and
// flags terminal count at zero. Holds at zero rather than wrapping.
module mux_scan_sequencer_dwell_timer #(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned LOAD_VAL = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= CNT_W'(LOAD_VAL);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 mux: steps the select through all channels, lets
// each settle for DWELL cycles, samples it, and delivers the 4-bit frame.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | mux disabled, sel=0, waiting for start
//  SETTLE  | mux enabled on current channel, dwell timer counting down
//  SAMPLE  | one cycle; mux output captured into shadow on exit
//  DELIVER | mux disabled; push shadow to the frame port (or stall/drop)
module mux_scan_sequencer
   import mux_scan_sequencer_pkg::*;
#(
   parameter int unsigned DWELL        = 4,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned DROP_ON_FULL = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       continuous_i,
   input  logic       mux_out_i,
   output logic [1:0] sel_o,
   output logic       mux_en_o,
   output logic       busy_o,
   output logic       overrun_o,
   mux_scan_sequencer_if.master frame_if
);

   scan_state_e state_q;
   logic [1:0]  chan_q;
   logic [1:0]  sel_q;
   logic        mux_en_q;
   logic        cont_q;
   logic        overrun_q;
   logic        valid_q;
   frame_t      shadow_q;
   frame_t      shadow_d;
   frame_t      frame_q;

   logic last_ch;
   logic deliver_ok;
   logic load_frame;
   logic drop_frame;
   logic move_on;
   logic tmr_load;
   logic tmr_dec;
   logic tmr_zero;

   assign last_ch    = (chan_q == LAST_CH);
   assign deliver_ok = !valid_q || frame_if.frame_ready;
   assign load_frame = (state_q == ST_DELIVER) && !stop_i && deliver_ok;
   assign drop_frame = (state_q == ST_DELIVER) && !stop_i && !deliver_ok
                       && (DROP_ON_FULL != 0);
   assign move_on    = load_frame || drop_frame;

   // The timer is reloaded on every entry into SETTLE.
   assign tmr_load = !stop_i &&
                     (((state_q == ST_IDLE) && start_i) ||
                      ((state_q == ST_SAMPLE) && !last_ch) ||
                      (move_on && cont_q));
   assign tmr_dec  = (state_q == ST_SETTLE) && !stop_i;

   always_comb begin
      shadow_d         = shadow_q;
      shadow_d[chan_q] = mux_out_i;
   end

   mux_scan_sequencer_dwell_timer #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (DWELL - 1)
   ) u_dwell_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (tmr_load),
      .dec_i  (tmr_dec),
      .zero_o (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         chan_q    <= 2'd0;
         sel_q     <= 2'd0;
         mux_en_q  <= 1'b0;
         cont_q    <= 1'b0;
         overrun_q <= 1'b0;
         valid_q   <= 1'b0;
         shadow_q  <= '0;
         frame_q   <= '0;
      end else begin
         // Frame port runs independently of stop so a pending frame survives an abort.
         if (load_frame) begin
            frame_q <= shadow_q;
            valid_q <= 1'b1;
         end else if (frame_if.frame_ready) begin
            valid_q <= 1'b0;
         end
         if (drop_frame) begin
            overrun_q <= 1'b1;
         end

         if (stop_i) begin
            state_q  <= ST_IDLE;
            chan_q   <= 2'd0;
            sel_q    <= 2'd0;
            mux_en_q <= 1'b0;
            shadow_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_i) begin
                     state_q   <= ST_SETTLE;
                     chan_q    <= 2'd0;
                     sel_q     <= 2'd0;
                     mux_en_q  <= 1'b1;
                     cont_q    <= continuous_i;
                     overrun_q <= 1'b0;
                  end
               end
               ST_SETTLE: begin
                  if (tmr_zero) begin
                     state_q <= ST_SAMPLE;
                  end
               end
               ST_SAMPLE: begin
                  shadow_q <= shadow_d;
                  if (last_ch) begin
                     state_q  <= ST_DELIVER;
                     mux_en_q <= 1'b0;
                  end else begin
                     state_q <= ST_SETTLE;
                     chan_q  <= chan_q + 2'd1;
                     sel_q   <= chan_q + 2'd1;
                  end
               end
               ST_DELIVER: begin
                  if (move_on) begin
                     chan_q <= 2'd0;
                     sel_q  <= 2'd0;
                     if (cont_q) begin
                        state_q  <= ST_SETTLE;
                        mux_en_q <= 1'b1;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign sel_o                = sel_q;
   assign mux_en_o             = mux_en_q;
   assign busy_o               = (state_q != ST_IDLE);
   assign overrun_o            = overrun_q;
   assign frame_if.frame       = frame_q;
   assign frame_if.frame_valid = valid_q;

endmodule
